// File: rtl/booth_r4_ctrl.sv
// Control FSM for a radix-4 Booth multiplier: load, recode, add/sub, 2-bit shift.
// Optional BOOTH_R4_SKIP_EN folds the shift into EVAL for zero digits (000/111).
module booth_r4_ctrl #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       q_bits,
  input  logic [CNT_W-1:0] count,
  output logic             ld_count,
  output logic             decr,
  output logic             ld_m,
  output logic             ld_q,
  output logic             clr_a,
  output logic             clr_qm1,
  output logic             alu_en,
  output logic             sub,
  output logic             sel_2m,
  output logic             shift,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_EVAL  = 3'd2,
    S_SHIFT = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t state_q;
  state_t state_d;
  logic   last_iter_s;

  // Counter is tested before its decrement; zero is treated as finished too.
  assign last_iter_s = (count <= {{(CNT_W-1){1'b0}}, 1'b1});

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_d  = state_q;
    ld_count = 1'b0;
    decr     = 1'b0;
    ld_m     = 1'b0;
    ld_q     = 1'b0;
    clr_a    = 1'b0;
    clr_qm1  = 1'b0;
    alu_en   = 1'b0;
    sub      = 1'b0;
    sel_2m   = 1'b0;
    shift    = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        busy     = 1'b1;
        ld_m     = 1'b1;
        ld_q     = 1'b1;
        clr_a    = 1'b1;
        clr_qm1  = 1'b1;
        ld_count = 1'b1;
        state_d  = S_EVAL;
      end
      S_EVAL: begin
        busy    = 1'b1;
        state_d = S_SHIFT;
        case (q_bits)
          3'b001, 3'b010: begin
            alu_en = 1'b1;
          end
          3'b011: begin
            alu_en = 1'b1;
            sel_2m = 1'b1;
          end
          3'b100: begin
            alu_en = 1'b1;
            sub    = 1'b1;
            sel_2m = 1'b1;
          end
          3'b101, 3'b110: begin
            alu_en = 1'b1;
            sub    = 1'b1;
          end
          3'b000, 3'b111: begin
`ifdef BOOTH_R4_SKIP_EN
            // Zero digit: shift straight away and skip the SHIFT state.
            shift = 1'b1;
            decr  = 1'b1;
            if (last_iter_s) begin
              state_d = S_DONE;
            end else begin
              state_d = S_EVAL;
            end
`else
            alu_en = 1'b0;
`endif
          end
          default: begin
            alu_en = 1'b0;
          end
        endcase
      end
      S_SHIFT: begin
        busy  = 1'b1;
        shift = 1'b1;
        decr  = 1'b1;
        if (last_iter_s) begin
          state_d = S_DONE;
        end else begin
          state_d = S_EVAL;
        end
      end
      S_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_booth_r4_ctrl.sv
// Directed bench for booth_r4_ctrl; models the iteration counter and checks every cycle.
module tb_booth_r4_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic [2:0] q_bits;
  logic [2:0] count;
  logic ld_count, decr, ld_m, ld_q, clr_a, clr_qm1, alu_en, sub, sel_2m, shift, busy, done;

  int checks = 0;
  int errors = 0;

  // Output vector order: ld_count decr ld_m ld_q clr_a clr_qm1 alu_en sub sel_2m shift busy done
  localparam logic [11:0] V_IDLE  = 12'b0000_0000_0000;
  localparam logic [11:0] V_LOAD  = 12'b1011_1100_0010;
  localparam logic [11:0] V_SHIFT = 12'b0100_0000_0110;
  localparam logic [11:0] V_DONE  = 12'b0000_0000_0011;

  booth_r4_ctrl #(.CNT_W(3)) dut (
    .clk(clk), .rst(rst), .start(start), .q_bits(q_bits), .count(count),
    .ld_count(ld_count), .decr(decr), .ld_m(ld_m), .ld_q(ld_q), .clr_a(clr_a),
    .clr_qm1(clr_qm1), .alu_en(alu_en), .sub(sub), .sel_2m(sel_2m), .shift(shift),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural iteration counter driven by the controller
  always @(posedge clk) begin
    if (rst) count <= 3'd0;
    else if (ld_count) count <= 3'd4;
    else if (decr) count <= count - 3'd1;
  end

  // sub/sel_2m only carry meaning while alu_en is high
  function automatic logic [11:0] outv();
    return {ld_count, decr, ld_m, ld_q, clr_a, clr_qm1, alu_en,
            sub & alu_en, sel_2m & alu_en, shift, busy, done};
  endfunction

  function automatic logic [11:0] exp_eval(input logic [2:0] q);
    logic [2:0] ase;
    case (q)
      3'b001, 3'b010: ase = 3'b100;
      3'b011:         ase = 3'b101;
      3'b100:         ase = 3'b111;
      3'b101, 3'b110: ase = 3'b110;
      default:        ase = 3'b000;
    endcase
    return {6'b000000, ase, 3'b010};
  endfunction

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full operation starting from IDLE; checks cycles 1..11
  task automatic run_op(input string tag, input logic [2:0] q0, input logic [2:0] q1,
                        input logic [2:0] q2, input logic [2:0] q3, input bit busy_start);
    logic [2:0] qs [4];
    logic [11:0] e;
    qs[0] = q0; qs[1] = q1; qs[2] = q2; qs[3] = q3;
    start = 1'b1;
    q_bits = 3'bxxx;
    tick();
    for (int c = 1; c <= 10; c++) begin
      start  = busy_start && (c >= 3) && (c <= 8);
      q_bits = ((c % 2) == 0 && c <= 8) ? qs[(c - 2) / 2] : 3'bxxx;
      #1;
      if (c == 1) e = V_LOAD;
      else if (c == 10) e = V_DONE;
      else if ((c % 2) == 0) e = exp_eval(qs[(c - 2) / 2]);
      else e = V_SHIFT;
      chk($sformatf("%s_c%0d", tag, c), outv(), e);
      @(posedge clk);
      #1;
    end
    start  = 1'b0;
    q_bits = 3'bxxx;
    #1;
    chk({tag, "_c11_idle"}, outv(), V_IDLE);
    chk({tag, "_cnt_end"}, {9'd0, count}, 12'd0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    q_bits = 3'bxxx;
    repeat (3) tick();
    chk("in_reset", outv(), V_IDLE);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("idle_%0d", i), outv(), V_IDLE);
    end

`ifndef BOOTH_R4_SKIP_EN
    run_op("normal", 3'b011, 3'b100, 3'b001, 3'b110, 1'b0);
    run_op("recode_lo", 3'b000, 3'b001, 3'b010, 3'b011, 1'b0);
    run_op("recode_hi", 3'b100, 3'b101, 3'b110, 3'b111, 1'b0);
    run_op("busy_start", 3'b001, 3'b111, 3'b101, 3'b000, 1'b1);

    // start in IDLE right after an operation: LOAD in the following cycle
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_load", outv(), V_LOAD);

    // Mid-operation reset during the second SHIFT
    q_bits = 3'b011;
    tick();
    chk("mid_eval", outv(), exp_eval(3'b011));
    q_bits = 3'bxxx;
    tick();
    chk("mid_shift1", outv(), V_SHIFT);
    q_bits = 3'b110;
    tick();
    chk("mid_eval2", outv(), exp_eval(3'b110));
    q_bits = 3'bxxx;
    tick();
    chk("mid_shift2", outv(), V_SHIFT);
    rst = 1'b1;
    tick();
    chk("mid_rst_idle", outv(), V_IDLE);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("mid_after_%0d", i), outv(), V_IDLE);
    end
`else
    // Zero multiplier: every digit is a single-cycle EVAL with shift/decr
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("skip_load", outv(), V_LOAD);
    q_bits = 3'b000;
    for (int c = 2; c <= 5; c++) begin
      tick();
      chk($sformatf("skip_eval_c%0d", c), outv(), V_SHIFT);
    end
    tick();
    q_bits = 3'bxxx;
    #1;
    chk("skip_done_c6", outv(), V_DONE);
    tick();
    chk("skip_idle_c7", outv(), V_IDLE);
    chk("skip_cnt_end", {9'd0, count}, 12'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
